// File: rtl/apb_master_if.sv
// Command/response and APB bus bundle for apb_master.
interface apb_master_if #(
    parameter int ADDR_W = 13
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic [3:0]        cmd_strb;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic              pready;
    logic [31:0]       prdata;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: command in, one APB transfer, response out.
module apb_master #(
    parameter int ADDR_W  = 13,
    parameter int TIMEOUT = 16
) (
    input  logic          pclk,
    input  logic          presetn,
    apb_master_if.master  bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              psel_q, psel_d;
    logic              pen_q, pen_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [31:0]       pwdata_q, pwdata_d;
    logic [3:0]        pstrb_q, pstrb_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rerr_q, rerr_d;
    logic              rto_q, rto_d;
    logic              cmd_ready;

    assign cmd_ready = presetn && (state_q == IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        psel_d   = psel_q;
        pen_d    = pen_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        rto_d    = rto_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready) begin
                    state_d  = SETUP;
                    cnt_d    = '0;
                    psel_d   = 1'b1;
                    pen_d    = 1'b0;
                    pwrite_d = bus.cmd_write;
                    paddr_d  = bus.cmd_addr;
                    pwdata_d = bus.cmd_write ? bus.cmd_wdata : 32'h0;
                    pstrb_d  = bus.cmd_write ? bus.cmd_strb : 4'h0;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                pen_d   = 1'b1;
            end
            ACCESS: begin
                // A completing pready always wins over the timeout
                if (bus.pready) begin
                    state_d  = RESP;
                    psel_d   = 1'b0;
                    pen_d    = 1'b0;
                    rvalid_d = 1'b1;
                    rerr_d   = bus.pslverr;
                    rto_d    = 1'b0;
                    rdata_d  = pwrite_q ? 32'h0 : bus.prdata;
                end else if (cnt_q == LAST) begin
                    state_d  = RESP;
                    psel_d   = 1'b0;
                    pen_d    = 1'b0;
                    rvalid_d = 1'b1;
                    rerr_d   = 1'b1;
                    rto_d    = 1'b1;
                    rdata_d  = 32'h0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            psel_q   <= 1'b0;
            pen_q    <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
            rto_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            psel_q   <= psel_d;
            pen_q    <= pen_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            rto_q    <= rto_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.psel        = psel_q;
    assign bus.penable     = pen_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pstrb       = pstrb_q;
    assign bus.rsp_valid   = rvalid_q;
    assign bus.rsp_rdata   = rdata_q;
    assign bus.rsp_err     = rerr_q;
    assign bus.rsp_timeout = rto_q;
endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed cases then random transfers vs a transaction model.
module tb_apb_master;
    localparam int AW = 13;
    localparam int TO = 16;

    logic pclk = 1'b0;
    logic presetn = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 pclk = ~pclk;

    apb_master_if #(.ADDR_W(AW)) bus ();

    apb_master #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 0);
        chk({tag, "_rsp_to"}, 32'(bus.rsp_timeout), 0);
        chk({tag, "_psel"}, 32'(bus.psel), 0);
        chk({tag, "_penable"}, 32'(bus.penable), 0);
        chk({tag, "_pwrite"}, 32'(bus.pwrite), 0);
        chk({tag, "_paddr"}, 32'(bus.paddr), 0);
        chk({tag, "_pwdata"}, bus.pwdata, 0);
        chk({tag, "_pstrb"}, 32'(bus.pstrb), 0);
    endtask

    // One complete transfer. Slave holds pready low for 'waits' ACCESS
    // cycles, then returns rd/serr; response held back for 'bp' cycles.
    task automatic xfer(input logic wr, input logic [AW-1:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        input int waits, input logic serr,
                        input logic [31:0] rd, input int bp);
        logic        to;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        logic [3:0]  exp_st;
        int          k;
        bit          done;
        logic [31:0] held;
        to      = (waits >= TO);
        exp_err = to ? 1'b1 : serr;
        exp_rd  = (wr || to) ? 32'h0 : rd;
        exp_wd  = wr ? wd : 32'h0;
        exp_st  = wr ? st : 4'h0;

        @(negedge pclk);
        chk("idle_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("idle_psel", 32'(bus.psel), 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = wd;
        bus.cmd_strb  = st;

        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        bus.cmd_write = ~wr;
        bus.cmd_addr  = AW'($urandom);
        bus.cmd_wdata = $urandom;
        bus.cmd_strb  = 4'($urandom);
        bus.pready    = 1'b0;
        chk("setup_psel", 32'(bus.psel), 1);
        chk("setup_penable", 32'(bus.penable), 0);
        chk("setup_cmd_ready", 32'(bus.cmd_ready), 0);
        chk("setup_pwrite", 32'(bus.pwrite), 32'(wr));
        chk("setup_paddr", 32'(bus.paddr), 32'(a));
        chk("setup_pwdata", bus.pwdata, exp_wd);
        chk("setup_pstrb", 32'(bus.pstrb), 32'(exp_st));

        k    = 0;
        done = 1'b0;
        for (int i = 0; i < TO + 4 && !done; i++) begin
            @(negedge pclk);
            if (bus.psel && bus.penable) begin
                k++;
                chk("acc_paddr", 32'(bus.paddr), 32'(a));
                chk("acc_pwdata", bus.pwdata, exp_wd);
                chk("acc_pstrb", 32'(bus.pstrb), 32'(exp_st));
                bus.pready  = (k > waits);
                bus.prdata  = (k > waits) ? rd : $urandom;
                bus.pslverr = (k > waits) ? serr : 1'($urandom);
            end else begin
                done = 1'b1;
            end
        end
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        chk("access_bound", 32'(done), 1);
        chk("penable_cycles", k, to ? TO : waits + 1);
        chk("resp_psel", 32'(bus.psel), 0);
        chk("resp_penable", 32'(bus.penable), 0);
        chk("rsp_valid", 32'(bus.rsp_valid), 1);
        chk("rsp_rdata", bus.rsp_rdata, exp_rd);
        chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(to));

        held = bus.rsp_rdata;
        for (int i = 0; i < bp; i++) begin
            bus.rsp_ready = 1'b0;
            bus.cmd_valid = 1'b1;
            @(negedge pclk);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 1);
            chk("bp_rsp_rdata", bus.rsp_rdata, held);
            chk("bp_rsp_err", 32'(bus.rsp_err), 32'(exp_err));
            chk("bp_cmd_ready", 32'(bus.cmd_ready), 0);
            chk("bp_psel", 32'(bus.psel), 0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge pclk);
        bus.rsp_ready = 1'b0;
        chk("done_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("done_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("done_psel", 32'(bus.psel), 0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_strb  = '0;
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        bus.prdata    = '0;
        bus.pslverr   = 1'b0;

        repeat (3) @(negedge pclk);
        chk_all_zero("rst");
        presetn = 1'b1;
        #1;
        chk("rst_release_ready", 32'(bus.cmd_ready), 1);

        xfer(1'b1, 13'h008, 32'h0000_00A5, 4'hF, 0, 1'b0, 32'hDEAD_BEEF, 0);
        xfer(1'b0, 13'h010, 32'h1234_5678, 4'hA, 2, 1'b0, 32'h0000_0003, 0);
        xfer(1'b1, 13'h1FFC, 32'hCAFE_0001, 4'h3, 1, 1'b1, 32'h0, 0);
        xfer(1'b0, 13'h004, 32'h0, 4'h0, TO, 1'b0, 32'h5555_AAAA, 0);
        xfer(1'b0, 13'h00C, 32'h0, 4'h0, TO - 1, 1'b0, 32'h7777_0001, 0);
        xfer(1'b0, 13'h020, 32'h0, 4'h0, 0, 1'b0, 32'h1357_9BDF, 5);

        // abort in the middle of ACCESS
        @(negedge pclk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 13'h040;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        @(negedge pclk);
        chk("abort_penable", 32'(bus.penable), 1);
        presetn = 1'b0;
        #1;
        chk_all_zero("abort");
        @(negedge pclk);
        bus.pready = 1'b1;
        @(negedge pclk);
        presetn = 1'b1;
        #1;
        chk("abort_release_ready", 32'(bus.cmd_ready), 1);
        @(negedge pclk);
        bus.pready = 1'b0;
        chk("abort_no_rsp", 32'(bus.rsp_valid), 0);
        chk("abort_psel", 32'(bus.psel), 0);
        chk("abort_cmd_ready", 32'(bus.cmd_ready), 1);

        for (int n = 0; n < 40; n++) begin
            int w;
            w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 2, TO + 2))
                                            : int'($urandom_range(0, 3));
            xfer(1'($urandom), AW'($urandom), $urandom, 4'($urandom), w,
                 1'($urandom), $urandom, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, APB address width.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles before abort (range 1..255).
REQ-003 SHALL have port pclk, input, 1, clock; all logic on rising edge.
REQ-004 SHALL have port presetn, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have cmd_valid input 1, request present; cmd_ready output 1, request accepted this cycle.
REQ-006 SHALL have cmd_write input 1 (1=write), cmd_addr input ADDR_W, cmd_wdata input 32, cmd_strb input 4.
REQ-007 SHALL have rsp_valid output 1, rsp_ready input 1, rsp_rdata output 32, rsp_err output 1, rsp_timeout output 1.
REQ-008 SHALL have APB outputs psel 1, penable 1, pwrite 1, paddr ADDR_W, pwdata 32, pstrb 4.
REQ-009 SHALL have APB inputs pready 1, prdata 32, pslverr 1.

Function
REQ-010 SHALL implement FSM with states IDLE, SETUP, ACCESS, RESP.
REQ-011 cmd_ready SHALL be 1 only in IDLE with presetn high; a command is accepted at an edge where cmd_valid and cmd_ready are both 1.
REQ-012 On acceptance SHALL latch cmd_write, cmd_addr, cmd_wdata, cmd_strb and go IDLE -> SETUP.
REQ-013 In SETUP SHALL drive psel=1, penable=0, latched pwrite/paddr/pwdata/pstrb; always exits to ACCESS after exactly one cycle.
REQ-014 In ACCESS SHALL drive psel=1, penable=1 with paddr, pwrite, pwdata, pstrb unchanged from SETUP.
REQ-015 For reads SHALL drive pstrb=4'b0000 and pwdata=0.
REQ-016 In ACCESS with pready=1 SHALL capture pslverr into rsp_err; for reads capture prdata into rsp_rdata, for writes set rsp_rdata=0; rsp_timeout=0; go to RESP.
REQ-017 SHALL count ACCESS cycles with an 8-bit wait counter cleared on SETUP entry.
REQ-018 When TIMEOUT ACCESS cycles have elapsed with pready=0, SHALL go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-019 If pready=1 in the TIMEOUT-th ACCESS cycle, SHALL treat it as a normal completion per REQ-016, not a timeout.
REQ-020 psel and penable SHALL both be 0 in IDLE and RESP; no APB transfer SHALL start while a response is pending.
REQ-021 In RESP SHALL hold rsp_valid=1 and rsp_rdata/rsp_err/rsp_timeout stable until rsp_ready=1, then go to IDLE.
REQ-022 Latency: for acceptance at edge N with pready=1 in the first ACCESS cycle, psel SHALL rise after N, penable after N+1, and rsp_valid after N+2.
REQ-023 Minimum issue interval SHALL be 4 cycles per transfer; there are no back-to-back APB transfers.
REQ-024 All APB and response outputs SHALL be registered, with no combinational path from pready/prdata to outputs.

Reset
REQ-025 presetn=0 SHALL immediately force state IDLE, wait counter 0, and every output to 0 (cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, penable, pwrite, paddr, pwdata, pstrb).
REQ-026 Reset asserted mid-transfer (SETUP/ACCESS/RESP) SHALL abandon the transfer with no response generated.
REQ-027 After presetn deasserts, cmd_ready SHALL be 1 from the first cycle with presetn high.

Verification
REQ-028 Write, no wait: cmd write addr 0x008 data 0x0000_00A5 strb 0xF, pready=1 -> one SETUP and one ACCESS cycle with paddr=0x008, pwdata=0xA5, pstrb=0xF; then rsp_valid with rsp_err=0, rsp_rdata=0.
REQ-029 Read with waits: read addr 0x010, pready low for 2 ACCESS cycles, prdata=0x0000_0003 on the third -> penable high for 3 cycles, pstrb=0, rsp_rdata=0x3, rsp_err=0.
REQ-030 Slave error: write addr 0x1FFC with pslverr=1 when pready=1 -> rsp_err=1, rsp_timeout=0.
REQ-031 Timeout: read with pready held 0, TIMEOUT=16 -> exactly 16 penable cycles, then psel=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-032 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and data stable, cmd_ready=0, psel=0 throughout; accepted on rsp_ready=1.
REQ-033 Reset mid-ACCESS: presetn low during ACCESS -> all outputs 0 immediately; after release, no rsp_valid and cmd_ready=1.
